// File: rtl/xgmii_tx_scheduler.sv
// XGMII TX scheduler: MAC-to-encoder sequencing with a skid FIFO, gearbox pause slots,
// startup idle preamble and underflow-to-error conversion. Optional stats: XGMII_TX_SCHED_PAUSE_STATS_EN.
module xgmii_tx_scheduler #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned PAUSE_PERIOD  = 32,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned STARTUP_IDLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_link_ready,
    input  logic [DATA_WIDTH-1:0] i_mac_txd,
    input  logic [CTRL_WIDTH-1:0] i_mac_txc,
    input  logic                  i_mac_valid,
    output logic                  o_mac_pause,
    output logic [DATA_WIDTH-1:0] o_enc_txd,
    output logic [CTRL_WIDTH-1:0] o_enc_txc,
    output logic                  o_enc_valid,
    output logic                  o_gb_pause,
    output logic                  o_overflow,
`ifdef XGMII_TX_SCHED_PAUSE_STATS_EN
    output logic                  o_underflow,
    output logic [15:0]           o_pause_cnt,
    output logic [15:0]           o_drop_cnt
`else
    output logic                  o_underflow
`endif
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned PCW = ($clog2(PAUSE_PERIOD + 1) > 6) ? $clog2(PAUSE_PERIOD + 1) : 6;
    localparam int unsigned ICW = $clog2(STARTUP_IDLES + 1);
    localparam int unsigned WW  = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [DATA_WIDTH-1:0] IDLE_D = {CTRL_WIDTH{8'h07}};
    localparam logic [DATA_WIDTH-1:0] ERR_D  = {CTRL_WIDTH{8'hFE}};

    typedef enum logic {
        ST_STARTUP = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [PCW-1:0]        r_pcnt, w_pcnt_nxt;
    logic                  w_pause_edge;
    logic                  r_parity;
    logic                  r_in_frame, w_in_frame_nxt;
    logic [ICW-1:0]        r_idle_cnt, w_idle_nxt;
    logic [WW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_rd_ptr, r_wr_ptr;
    logic [AW:0]           r_count, w_count_nxt;
    logic [WW-1:0]         w_head;
    logic                  w_empty, w_full;
    logic                  w_emit, w_pop, w_push_req, w_push, w_drop, w_flush, w_unf_set;
    logic                  w_fd, w_sof;
    logic [DATA_WIDTH-1:0] w_txd;
    logic [CTRL_WIDTH-1:0] w_txc;
    logic                  w_mac_pause_nxt;

    always_comb begin
        w_pcnt_nxt   = (r_pcnt == PCW'(PAUSE_PERIOD)) ? '0 : r_pcnt + PCW'(1);
        w_pause_edge = (w_pcnt_nxt == PCW'(PAUSE_PERIOD));
        w_head       = r_mem[r_rd_ptr];
        w_empty      = (r_count == '0);
        w_full       = (r_count == (AW+1)'(FIFO_DEPTH));

        w_fd = 1'b0;
        for (int unsigned i = 0; i < CTRL_WIDTH; i++) begin
            if (w_head[DATA_WIDTH+i] && (w_head[8*i +: 8] == 8'hFD)) begin
                w_fd = 1'b1;
            end
        end
        w_sof = w_head[DATA_WIDTH] && (w_head[7:0] == 8'hFB);

        w_state_nxt    = r_state;
        w_in_frame_nxt = r_in_frame;
        w_idle_nxt     = r_idle_cnt;
        w_emit         = 1'b0;
        w_pop          = 1'b0;
        w_push_req     = 1'b0;
        w_flush        = 1'b0;
        w_unf_set      = 1'b0;
        w_txd          = IDLE_D;
        w_txc          = '1;

        case (r_state)
            ST_STARTUP: begin
                w_flush = 1'b1;
                if (!w_pause_edge) begin
                    w_emit = 1'b1;
                    if (r_idle_cnt < ICW'(STARTUP_IDLES)) begin
                        w_idle_nxt = r_idle_cnt + ICW'(1);
                    end
                end
                if ((r_idle_cnt >= ICW'(STARTUP_IDLES)) && i_link_ready && !r_parity) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Link loss waits out a pause slot only when a block half is still owed.
                if (!i_link_ready && (!r_parity || !w_pause_edge)) begin
                    w_state_nxt    = ST_STARTUP;
                    w_flush        = 1'b1;
                    w_in_frame_nxt = 1'b0;
                    w_idle_nxt     = '0;
                    if (r_parity) begin
                        w_emit = 1'b1;
                        if (!w_empty) begin
                            w_pop = 1'b1;
                            w_txd = w_head[DATA_WIDTH-1:0];
                            w_txc = w_head[WW-1:DATA_WIDTH];
                        end
                    end
                end else begin
                    w_push_req = i_mac_valid;
                    if (!w_pause_edge) begin
                        w_emit = 1'b1;
                        if (!w_empty) begin
                            w_pop = 1'b1;
                            w_txd = w_head[DATA_WIDTH-1:0];
                            w_txc = w_head[WW-1:DATA_WIDTH];
                            if (w_fd) begin
                                w_in_frame_nxt = 1'b0;
                            end else if (w_sof) begin
                                w_in_frame_nxt = 1'b1;
                            end
                        end else if (r_in_frame) begin
                            w_txd     = ERR_D;
                            w_unf_set = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_STARTUP;
        endcase

        w_drop = w_push_req && w_full && !w_pop;
        w_push = w_push_req && !w_drop;
        if (w_flush) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
        w_mac_pause_nxt = (w_state_nxt != ST_RUN) || (w_count_nxt >= (AW+1)'(FIFO_DEPTH - 2));
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_STARTUP;
            r_pcnt      <= '0;
            r_parity    <= 1'b0;
            r_in_frame  <= 1'b0;
            r_idle_cnt  <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            o_enc_valid <= 1'b0;
            o_enc_txd   <= IDLE_D;
            o_enc_txc   <= '1;
            o_mac_pause <= 1'b1;
            o_gb_pause  <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pcnt      <= w_pcnt_nxt;
            r_parity    <= r_parity ^ w_emit;
            r_in_frame  <= w_in_frame_nxt;
            r_idle_cnt  <= w_idle_nxt;
            r_count     <= w_count_nxt;
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
            end
            o_enc_valid <= w_emit;
            o_enc_txd   <= w_txd;
            o_enc_txc   <= w_txc;
            o_mac_pause <= w_mac_pause_nxt;
            o_gb_pause  <= w_pause_edge;
            o_overflow  <= o_overflow | w_drop;
            o_underflow <= o_underflow | w_unf_set;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_mac_txc, i_mac_txd};
        end
    end

`ifdef XGMII_TX_SCHED_PAUSE_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_pause_cnt <= '0;
            o_drop_cnt  <= '0;
        end else begin
            if (w_pause_edge && (o_pause_cnt != '1)) begin
                o_pause_cnt <= o_pause_cnt + 16'd1;
            end
            if (w_drop && (o_drop_cnt != '1)) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xgmii_tx_scheduler.sv
// Randomised bench for xgmii_tx_scheduler against a queue-based reference model.
module tb_xgmii_tx_scheduler;

    localparam int PP    = 32;
    localparam int DEPTH = 4;
    localparam int SI    = 16;
    localparam logic [31:0] IDLE = 32'h07070707;
    localparam logic [31:0] ERR  = 32'hFEFEFEFE;

    logic        clk, rst_n, link, mv;
    logic [31:0] txd;
    logic [3:0]  txc;
    logic        o_mac_pause, o_enc_valid, o_gb_pause, o_overflow, o_underflow;
    logic [31:0] o_enc_txd;
    logic [3:0]  o_enc_txc;
`ifdef XGMII_TX_SCHED_PAUSE_STATS_EN
    logic [15:0] o_pause_cnt, o_drop_cnt;
`endif

    xgmii_tx_scheduler #(
        .DATA_WIDTH(32), .PAUSE_PERIOD(PP), .FIFO_DEPTH(DEPTH), .STARTUP_IDLES(SI)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_link_ready(link),
        .i_mac_txd(txd), .i_mac_txc(txc), .i_mac_valid(mv),
        .o_mac_pause(o_mac_pause), .o_enc_txd(o_enc_txd), .o_enc_txc(o_enc_txc),
        .o_enc_valid(o_enc_valid), .o_gb_pause(o_gb_pause),
        .o_overflow(o_overflow),
`ifdef XGMII_TX_SCHED_PAUSE_STATS_EN
        .o_underflow(o_underflow), .o_pause_cnt(o_pause_cnt), .o_drop_cnt(o_drop_cnt)
`else
        .o_underflow(o_underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_run, m_in_frame, m_par, m_ovf, m_unf;
    int          m_idles, m_edge, m_drops;
    logic [35:0] m_q[$];
    logic        e_valid, e_gbp, e_macp;
    logic [31:0] e_txd;
    logic [3:0]  e_txc;
    logic [40:0] act, exp;

    function automatic void model_step();
        logic [35:0] w;
        bit pause, go, fd;
        if (!rst_n) begin
            m_run = 0; m_in_frame = 0; m_par = 0; m_ovf = 0; m_unf = 0;
            m_idles = 0; m_edge = 0; m_drops = 0; m_q.delete();
            e_valid = 0; e_txd = IDLE; e_txc = 4'hF; e_gbp = 0; e_macp = 1;
            return;
        end
        m_edge++;
        pause = (m_edge % (PP + 1)) == PP;
        e_gbp = pause; e_valid = 0; e_txd = IDLE; e_txc = 4'hF;
        if (!m_run) begin
            go = (m_idles >= SI) && link && !m_par;
            if (!pause) begin e_valid = 1; m_idles++; end
            if (go) m_run = 1;
        end else if (!link && (!m_par || !pause)) begin
            if (m_par) begin
                e_valid = 1;
                if (m_q.size() > 0) begin
                    w = m_q.pop_front(); e_txd = w[31:0]; e_txc = w[35:32];
                end
            end
            m_q.delete(); m_in_frame = 0; m_idles = 0; m_run = 0;
        end else begin
            if (!pause) begin
                e_valid = 1;
                if (m_q.size() > 0) begin
                    w = m_q.pop_front(); e_txd = w[31:0]; e_txc = w[35:32];
                    fd = 0;
                    for (int j = 0; j < 4; j++) if (w[32+j] && w[8*j +: 8] == 8'hFD) fd = 1;
                    if (fd) m_in_frame = 0;
                    else if (w[32] && w[7:0] == 8'hFB) m_in_frame = 1;
                end else if (m_in_frame) begin
                    e_txd = ERR; m_unf = 1;
                end
            end
            if (mv) begin
                if (m_q.size() >= DEPTH) begin m_ovf = 1; m_drops++; end
                else m_q.push_back({txc, txd});
            end
        end
        if (e_valid) m_par = !m_par;
        e_macp = !m_run || (m_q.size() >= DEPTH - 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        act = {o_enc_valid, o_enc_txd, o_enc_txc, o_gb_pause, o_mac_pause, o_overflow, o_underflow};
        exp = {e_valid, e_txd, e_txc, e_gbp, e_macp, m_ovf, m_unf};
    endtask

    function automatic logic [35:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       return {4'h1, r[31:8], 8'hFB};
            1:       return {4'hF, 24'h070707, 8'hFD};
            default: return {4'h0, r};
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 0; link = 1; mv = 0; txd = '0; txc = '0;
        repeat (3) tick();
        n_tests++; if (o_enc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_enc_valid); end
        n_tests++; if (o_enc_txd !== IDLE) begin n_fail++; $display("FAIL reset_txd: got %h want %h", o_enc_txd, IDLE); end
        n_tests++; if (o_enc_txc !== 4'hF) begin n_fail++; $display("FAIL reset_txc: got %h want F", o_enc_txc); end
        n_tests++; if (o_mac_pause !== 1'b1) begin n_fail++; $display("FAIL reset_mac_pause: got %b want 1", o_mac_pause); end
        n_tests++; if (o_gb_pause !== 1'b0) begin n_fail++; $display("FAIL reset_gb_pause: got %b want 0", o_gb_pause); end
        n_tests++; if ({o_overflow, o_underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {o_overflow, o_underflow}); end
    endtask

    task automatic test_startup();
        int idles_paused = 0;
        int first_gbp = -1;
        rst_n = 1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            n_tests++;
            if (act !== exp) begin n_fail++; $display("FAIL startup edge %0d: got %h want %h", c, act, exp); end
            if (o_enc_valid && o_mac_pause && o_enc_txd == IDLE && o_enc_txc == 4'hF) idles_paused++;
            if (o_gb_pause && first_gbp < 0) first_gbp = c;
        end
        n_tests++; if (idles_paused !== SI) begin n_fail++; $display("FAIL startup_idles: got %0d want %0d", idles_paused, SI); end
        n_tests++; if (first_gbp !== PP) begin n_fail++; $display("FAIL first_gb_pause: got %0d want %0d", first_gbp, PP); end
    endtask

    task automatic test_frame();
        logic [35:0] sent[$], got[$];
        int idx = 0;
        sent.push_back({4'h1, 32'h555555FB});
        for (int i = 0; i < 8; i++) sent.push_back({4'h0, 32'($urandom)});
        sent.push_back({4'hE, 32'h0707FDA5});
        for (int c = 0; c < 120; c++) begin
            if (idx < sent.size() && !o_mac_pause) begin
                mv = 1; {txc, txd} = sent[idx]; idx++;
            end else mv = 0;
            tick();
            n_tests++;
            if (act !== exp) begin n_fail++; $display("FAIL frame edge %0d: got %h want %h", m_edge, act, exp); end
            if (o_enc_valid && {o_enc_txc, o_enc_txd} != {4'hF, IDLE}) got.push_back({o_enc_txc, o_enc_txd});
        end
        mv = 0;
        n_tests++; if (got.size() !== sent.size()) begin n_fail++; $display("FAIL frame_len: got %0d want %0d", got.size(), sent.size()); end
        for (int i = 0; i < sent.size() && i < got.size(); i++) begin
            n_tests++; if (got[i] !== sent[i]) begin n_fail++; $display("FAIL frame_word%0d: got %h want %h", i, got[i], sent[i]); end
        end
        n_tests++; if ({o_overflow, o_underflow} !== 2'b00) begin n_fail++; $display("FAIL frame_flags: got %b want 00", {o_overflow, o_underflow}); end
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 180; c++) begin
            mv = (c < 160);
            txc = 4'h0; txd = $urandom;
            tick();
            n_tests++;
            if (act !== exp) begin n_fail++; $display("FAIL overflow edge %0d: got %h want %h", m_edge, act, exp); end
        end
        mv = 0;
        n_tests++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_flag: got %b want 1", o_overflow); end
`ifdef XGMII_TX_SCHED_PAUSE_STATS_EN
        n_tests++; if (o_drop_cnt !== 16'(m_drops)) begin n_fail++; $display("FAIL drop_cnt: got %0d want %0d", o_drop_cnt, m_drops); end
`endif
    endtask

    task automatic test_underflow();
        logic [36:0] sched[$];
        logic [35:0] sent[$], got[$];
        sched.push_back({1'b1, 4'h1, 32'hABCDEFFB});
        for (int i = 0; i < 2; i++) sched.push_back({1'b1, 4'h0, 32'($urandom)});
        for (int i = 0; i < 3; i++) sched.push_back({1'b0, 36'h0});
        for (int i = 0; i < 3; i++) sched.push_back({1'b1, 4'h0, 32'($urandom)});
        sched.push_back({1'b1, 4'hF, 32'h070707FD});
        foreach (sched[i]) if (sched[i][36]) sent.push_back(sched[i][35:0]);
        for (int c = 0; c < 60; c++) begin
            mv = 0;
            if (sched.size() > 0) begin
                if (!sched[0][36]) void'(sched.pop_front());
                else if (!o_mac_pause) begin mv = 1; {txc, txd} = sched[0][35:0]; void'(sched.pop_front()); end
            end
            tick();
            n_tests++;
            if (act !== exp) begin n_fail++; $display("FAIL underflow edge %0d: got %h want %h", m_edge, act, exp); end
            if (o_enc_valid && {o_enc_txc, o_enc_txd} != {4'hF, IDLE} && {o_enc_txc, o_enc_txd} != {4'hF, ERR})
                got.push_back({o_enc_txc, o_enc_txd});
        end
        mv = 0;
        n_tests++; if (o_underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_flag: got %b want 1", o_underflow); end
        n_tests++; if (got.size() !== sent.size()) begin n_fail++; $display("FAIL underflow_len: got %0d want %0d", got.size(), sent.size()); end
        for (int i = 0; i < sent.size() && i < got.size(); i++) begin
            n_tests++; if (got[i] !== sent[i]) begin n_fail++; $display("FAIL resume_word%0d: got %h want %h", i, got[i], sent[i]); end
        end
    endtask

    task automatic test_link_loss();
        bit found = 0;
        mv = 0; link = 1;
        for (int c = 0; c < 10 && !found; c++) begin
            if (m_run && m_par && ((m_edge + 1) % (PP + 1)) != PP) found = 1;
            else begin
                tick();
                n_tests++;
                if (act !== exp) begin n_fail++; $display("FAIL linkwait edge %0d: got %h want %h", m_edge, act, exp); end
            end
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL link_wait: got timeout want odd parity slot"); end
        link = 0;
        tick();
        n_tests++; if (o_enc_valid !== 1'b1) begin n_fail++; $display("FAIL link_complete: got %b want 1", o_enc_valid); end
        n_tests++; if (act !== exp) begin n_fail++; $display("FAIL link_drop edge %0d: got %h want %h", m_edge, act, exp); end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (act !== exp) begin n_fail++; $display("FAIL linkdown edge %0d: got %h want %h", m_edge, act, exp); end
        end
        n_tests++; if (o_mac_pause !== 1'b1) begin n_fail++; $display("FAIL linkdown_pause: got %b want 1", o_mac_pause); end
        link = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            n_tests++;
            if (act !== exp) begin n_fail++; $display("FAIL relink edge %0d: got %h want %h", m_edge, act, exp); end
        end
        n_tests++; if (o_mac_pause !== 1'b0) begin n_fail++; $display("FAIL relink_run: got %b want 0", o_mac_pause); end
    endtask

    task automatic test_random();
        bit obey;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 59) == 0) link = ~link;
            obey = ($urandom_range(0, 9) != 0);
            mv = ($urandom_range(0, 3) != 0) && !(obey && o_mac_pause);
            {txc, txd} = rand_word();
            tick();
            n_tests++;
            if (act !== exp) begin n_fail++; $display("FAIL random cycle %0d: got %h want %h", c, act, exp); end
        end
        rst_n = 1; link = 1; mv = 0;
    endtask

`ifdef XGMII_TX_SCHED_PAUSE_STATS_EN
    task automatic test_stats();
        rst_n = 0; mv = 0; link = 1;
        tick();
        rst_n = 1;
        repeat (330) tick();
        n_tests++; if (o_pause_cnt !== 16'd10) begin n_fail++; $display("FAIL pause_cnt: got %0d want 10", o_pause_cnt); end
        n_tests++; if (o_drop_cnt !== 16'd0) begin n_fail++; $display("FAIL drop_cnt_idle: got %0d want 0", o_drop_cnt); end
    endtask
`endif

    initial begin
        rst_n = 0; link = 1; mv = 0; txd = '0; txc = '0;
        test_reset();
        test_startup();
        test_frame();
        test_overflow();
        test_underflow();
        test_link_loss();
        test_random();
`ifdef XGMII_TX_SCHED_PAUSE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
